// File: rtl/uart_pkg.sv
// Shared UART constants and helpers used by the RX and TX side controllers.
package uart_pkg;

    localparam int unsigned EOF_BIT              = 8;
    localparam int unsigned DEFAULT_IDLE_TIMEOUT = 320;
    localparam int unsigned STATS_CNT_WIDTH      = 16;
    localparam int unsigned SAT_W                = 32;

    // Increment that sticks at max_val instead of wrapping.
    function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] val,
                                                 input logic [SAT_W-1:0] max_val);
        return (val == max_val) ? val : val + SAT_W'(1);
    endfunction

endpackage

// File: rtl/uart_idle_timer.sv
// Idle-line counter: counts enabled cycles up to TIMEOUT-1 and flags the cycle
// in which it reaches that value. Shared by the RX and TX controllers.
module uart_idle_timer
    import uart_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_IDLE_TIMEOUT
) (
    input  logic clk_in,
    input  logic n_rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_c_o
);

    localparam int unsigned CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST     = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] PRE_LAST = CW'(TIMEOUT - 2);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != LAST)) begin
            count_d = count_q + CW'(1);
        end
    end

    // Terminal flag coincides with the edge that loads LAST.
    assign tc_c_o = en_i & ~clr_i & (count_q == PRE_LAST);

    always_ff @(posedge clk_in or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: stages bytes into the RX FIFO, inserts end-of-frame
// markers after idle gaps. Statistics counters built only with UART_RX_CTRL_STATS_EN.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS    = EOF_BIT,
    parameter int unsigned IDLE_TIMEOUT = DEFAULT_IDLE_TIMEOUT,
    parameter int unsigned CNT_WIDTH    = STATS_CNT_WIDTH
) (
    input  logic                 clk_in,
    input  logic                 n_rst,
    input  logic                 enable,
    input  logic                 clr_stats,
    input  logic                 rx_valid,
    input  logic [DATA_BITS-1:0] rx_data,
    input  logic                 rx_ready,
    input  logic                 fifo_full,
    output logic                 fifo_wr,
    output logic [DATA_BITS:0]   fifo_wdata,
    output logic [CNT_WIDTH-1:0] overrun_cnt,
    output logic [CNT_WIDTH-1:0] frame_cnt,
    output logic                 busy
);

    localparam int unsigned WORD_W = DATA_BITS + 1;

    logic              stage_valid_q, stage_valid_d;
    logic [WORD_W-1:0] stage_word_q, stage_word_d;
    logic              frame_open_q, frame_open_d;
    logic              eof_pend_q, eof_pend_d;

    logic accept, stage_free, capture, overrun, insert_marker;
    logic timer_en, timer_clr, timer_tc;

    // Stage handshake; a draining stage counts as free so throughput is one word per cycle.
    always_comb begin
        fifo_wr       = stage_valid_q & ~fifo_full;
        accept        = rx_valid & enable;
        stage_free    = ~stage_valid_q | fifo_wr;
        capture       = accept & stage_free;
        overrun       = accept & ~stage_free;
        insert_marker = eof_pend_q & stage_free & ~capture;
        timer_en      = enable & frame_open_q & rx_ready & ~rx_valid & ~eof_pend_q;
        timer_clr     = rx_valid | ~rx_ready | ~enable;
    end

    assign fifo_wdata = stage_word_q;
    assign busy       = stage_valid_q | frame_open_q;

    uart_idle_timer #(
        .TIMEOUT (IDLE_TIMEOUT)
    ) u_idle_timer (
        .clk_in (clk_in),
        .n_rst  (n_rst),
        .clr_i  (timer_clr),
        .en_i   (timer_en),
        .tc_c_o (timer_tc)
    );

    // Data wins over the marker; a pending marker simply waits one more cycle.
    always_comb begin
        stage_valid_d = stage_valid_q;
        stage_word_d  = stage_word_q;
        frame_open_d  = frame_open_q;
        eof_pend_d    = eof_pend_q;
        if (capture) begin
            stage_valid_d = 1'b1;
            stage_word_d  = {1'b0, rx_data};
        end else if (insert_marker) begin
            stage_valid_d = 1'b1;
            stage_word_d  = {1'b1, {DATA_BITS{1'b0}}};
        end else if (fifo_wr) begin
            stage_valid_d = 1'b0;
        end
        if (capture) begin
            frame_open_d = 1'b1;
        end else if (insert_marker) begin
            frame_open_d = 1'b0;
        end
        if (insert_marker) begin
            eof_pend_d = 1'b0;
        end else if (timer_tc || (!enable && frame_open_q)) begin
            eof_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge n_rst) begin
        if (!n_rst) begin
            stage_valid_q <= 1'b0;
            stage_word_q  <= '0;
            frame_open_q  <= 1'b0;
            eof_pend_q    <= 1'b0;
        end else begin
            stage_valid_q <= stage_valid_d;
            stage_word_q  <= stage_word_d;
            frame_open_q  <= frame_open_d;
            eof_pend_q    <= eof_pend_d;
        end
    end

`ifdef UART_RX_CTRL_STATS_EN
    localparam logic [SAT_W-1:0] CNT_MAX = SAT_W'({CNT_WIDTH{1'b1}});

    logic [CNT_WIDTH-1:0] overrun_cnt_q, overrun_cnt_d;
    logic [CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
    logic                 marker_push;

    // Clear beats increment; both counters saturate.
    always_comb begin
        overrun_cnt_d = overrun_cnt_q;
        frame_cnt_d   = frame_cnt_q;
        marker_push   = fifo_wr & stage_word_q[DATA_BITS];
        if (clr_stats) begin
            overrun_cnt_d = '0;
            frame_cnt_d   = '0;
        end else begin
            if (overrun) begin
                overrun_cnt_d = CNT_WIDTH'(sat_inc(SAT_W'(overrun_cnt_q), CNT_MAX));
            end
            if (marker_push) begin
                frame_cnt_d = CNT_WIDTH'(sat_inc(SAT_W'(frame_cnt_q), CNT_MAX));
            end
        end
    end

    always_ff @(posedge clk_in or negedge n_rst) begin
        if (!n_rst) begin
            overrun_cnt_q <= '0;
            frame_cnt_q   <= '0;
        end else begin
            overrun_cnt_q <= overrun_cnt_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign overrun_cnt = overrun_cnt_q;
    assign frame_cnt   = frame_cnt_q;
`else
    logic unused_stats;
    assign unused_stats = clr_stats ^ overrun;
    assign overrun_cnt  = '0;
    assign frame_cnt    = '0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: vector table plus hand sequences for
// marker timing, disable, stats clear and asynchronous reset.
module tb_uart_rx_ctrl;

    localparam int unsigned T = 8;

    logic        clk_in = 1'b0;
    logic        n_rst;
    logic        enable;
    logic        clr_stats;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        fifo_full;
    logic        fifo_wr;
    logic [8:0]  fifo_wdata;
    logic [15:0] overrun_cnt;
    logic [15:0] frame_cnt;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk_in = ~clk_in;

    uart_rx_ctrl #(
        .DATA_BITS    (8),
        .IDLE_TIMEOUT (T),
        .CNT_WIDTH    (16)
    ) dut (
        .clk_in      (clk_in),
        .n_rst       (n_rst),
        .enable      (enable),
        .clr_stats   (clr_stats),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_ready    (rx_ready),
        .fifo_full   (fifo_full),
        .fifo_wr     (fifo_wr),
        .fifo_wdata  (fifo_wdata),
        .overrun_cnt (overrun_cnt),
        .frame_cnt   (frame_cnt),
        .busy        (busy)
    );

    typedef struct {
        logic       rv;
        logic [7:0] data;
        logic       full;
        logic       exp_wr;
        logic [8:0] exp_wdata;
        logic       exp_busy;
        int         exp_ovr;
    } vec_t;

    vec_t vecs[13];

    // Counters read as zero when the statistics block is not built.
    function automatic int ec(input int v);
`ifdef UART_RX_CTRL_STATS_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rv, input logic [7:0] d);
        rx_valid = rv;
        rx_data  = d;
    endtask

    task automatic settle();
        @(negedge clk_in);
    endtask

    task automatic adv();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_marker(input string name);
        bit got;
        got = 1'b0;
        for (int i = 0; i < int'(T) + 6 && !got; i++) begin
            drive(1'b0, 8'h00);
            settle();
            if (fifo_wr && fifo_wdata[8]) got = 1'b1;
            adv();
        end
        chk(name, 32'(got), 32'(1));
    endtask

    initial begin
        int extra;
        logic       exp_wr;
        logic [8:0] exp_d;

        vecs[0]  = '{1'b0, 8'h00, 1'b0, 1'b0, 9'h000, 1'b0, 0};
        vecs[1]  = '{1'b1, 8'h5A, 1'b0, 1'b0, 9'h000, 1'b0, 0};
        vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b1, 9'h05A, 1'b1, 0};
        vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 9'h05A, 1'b1, 0};
        vecs[4]  = '{1'b1, 8'h11, 1'b1, 1'b0, 9'h05A, 1'b1, 0};
        vecs[5]  = '{1'b1, 8'h22, 1'b1, 1'b0, 9'h011, 1'b1, 0};
        vecs[6]  = '{1'b1, 8'h33, 1'b1, 1'b0, 9'h011, 1'b1, 1};
        vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 9'h011, 1'b1, 2};
        vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 9'h011, 1'b1, 2};
        vecs[9]  = '{1'b1, 8'hA0, 1'b0, 1'b0, 9'h011, 1'b1, 2};
        vecs[10] = '{1'b1, 8'hA1, 1'b0, 1'b1, 9'h0A0, 1'b1, 2};
        vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 9'h0A1, 1'b1, 2};
        vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 9'h0A1, 1'b1, 2};

        n_rst     = 1'b0;
        enable    = 1'b1;
        clr_stats = 1'b0;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        rx_ready  = 1'b1;
        fifo_full = 1'b0;

        #12;
        chk("reset wr",    32'(fifo_wr),     32'(0));
        chk("reset wdata", 32'(fifo_wdata),  32'(0));
        chk("reset busy",  32'(busy),        32'(0));
        chk("reset ovr",   32'(overrun_cnt), 32'(0));
        chk("reset frame", 32'(frame_cnt),   32'(0));
        @(negedge clk_in);
        n_rst = 1'b1;
        adv();

        // Capture latency, overrun under full FIFO, drain-and-capture in one cycle.
        foreach (vecs[i]) begin
            drive(vecs[i].rv, vecs[i].data);
            fifo_full = vecs[i].full;
            settle();
            chk($sformatf("v%0d wr", i),    32'(fifo_wr),     32'(vecs[i].exp_wr));
            chk($sformatf("v%0d wdata", i), 32'(fifo_wdata),  32'(vecs[i].exp_wdata));
            chk($sformatf("v%0d busy", i),  32'(busy),        32'(vecs[i].exp_busy));
            chk($sformatf("v%0d ovr", i),   32'(overrun_cnt), 32'(ec(vecs[i].exp_ovr)));
            adv();
        end
        fifo_full = 1'b0;
        wait_marker("table marker");
        settle();
        chk("table frame", 32'(frame_cnt), 32'(ec(1)));
        chk("table busy",  32'(busy),      32'(0));
        adv();

        // Marker lands exactly T+1 cycles after the last byte.
        drive(1'b1, 8'h3C);
        adv();
        for (int k = 1; k <= int'(T) + 2; k++) begin
            drive(1'b0, 8'h00);
            settle();
            exp_wr = (k == 1) || (k == int'(T) + 1);
            exp_d  = (k < int'(T) + 1) ? 9'h03C : 9'h100;
            chk($sformatf("lat k%0d wr", k),    32'(fifo_wr),    32'(exp_wr));
            chk($sformatf("lat k%0d wdata", k), 32'(fifo_wdata), 32'(exp_d));
            adv();
        end
        chk("lat frame", 32'(frame_cnt), 32'(ec(2)));

        // Byte arriving in the cycle the marker becomes pending goes first.
        drive(1'b1, 8'h10);
        adv();
        for (int k = 1; k <= int'(T) + 2; k++) begin
            if (k == int'(T)) drive(1'b1, 8'h77);
            else              drive(1'b0, 8'h00);
            settle();
            exp_wr = (k == 1) || (k == int'(T) + 1) || (k == int'(T) + 2);
            exp_d  = (k < int'(T) + 1) ? 9'h010 : ((k == int'(T) + 1) ? 9'h077 : 9'h100);
            chk($sformatf("tmo k%0d wr", k),    32'(fifo_wr),    32'(exp_wr));
            chk($sformatf("tmo k%0d wdata", k), 32'(fifo_wdata), 32'(exp_d));
            adv();
        end
        extra = 0;
        for (int k = 0; k < 2 * int'(T); k++) begin
            drive(1'b0, 8'h00);
            settle();
            if (fifo_wr) extra++;
            adv();
        end
        chk("tmo extra pushes", 32'(extra), 32'(0));
        chk("tmo frame", 32'(frame_cnt), 32'(ec(3)));
        chk("tmo busy",  32'(busy),      32'(0));

        // Disable closes the open frame and ignores further bytes.
        drive(1'b1, 8'h42);
        adv();
        drive(1'b0, 8'h00);
        settle();
        chk("dis byte wr",    32'(fifo_wr),    32'(1));
        chk("dis byte wdata", 32'(fifo_wdata), 32'(9'h042));
        adv();
        enable = 1'b0;
        settle();
        adv();
        drive(1'b1, 8'h99);
        settle();
        chk("dis k3 wr", 32'(fifo_wr), 32'(0));
        adv();
        drive(1'b0, 8'h00);
        settle();
        chk("dis marker wr",    32'(fifo_wr),    32'(1));
        chk("dis marker wdata", 32'(fifo_wdata), 32'(9'h100));
        adv();
        drive(1'b1, 8'h98);
        settle();
        chk("dis k5 wr", 32'(fifo_wr), 32'(0));
        adv();
        drive(1'b0, 8'h00);
        settle();
        chk("dis k6 wr",    32'(fifo_wr),     32'(0));
        chk("dis k6 wdata", 32'(fifo_wdata),  32'(9'h100));
        chk("dis k6 busy",  32'(busy),        32'(0));
        chk("dis ovr",      32'(overrun_cnt), 32'(ec(2)));
        chk("dis frame",    32'(frame_cnt),   32'(ec(4)));
        adv();
        enable = 1'b1;

        // Clear wins over a simultaneous overrun.
        fifo_full = 1'b1;
        drive(1'b1, 8'h01);
        adv();
        drive(1'b1, 8'h02);
        clr_stats = 1'b1;
        settle();
        chk("clr pre ovr", 32'(overrun_cnt), 32'(ec(2)));
        chk("clr hold wr", 32'(fifo_wr),     32'(0));
        adv();
        drive(1'b0, 8'h00);
        clr_stats = 1'b0;
        fifo_full = 1'b0;
        settle();
        chk("clr ovr",   32'(overrun_cnt), 32'(0));
        chk("clr frame", 32'(frame_cnt),   32'(0));
        chk("clr wr",    32'(fifo_wr),     32'(1));
        chk("clr wdata", 32'(fifo_wdata),  32'(9'h001));
        adv();
        wait_marker("clr marker");
        settle();
        chk("clr frame after", 32'(frame_cnt), 32'(ec(1)));
        adv();

        // Asynchronous reset mid-frame drops the staged byte and the marker.
        fifo_full = 1'b1;
        drive(1'b1, 8'h55);
        adv();
        drive(1'b0, 8'h00);
        settle();
        chk("rst held wr",    32'(fifo_wr),    32'(0));
        chk("rst held wdata", 32'(fifo_wdata), 32'(9'h055));
        fifo_full = 1'b0;
        #1;
        chk("rst pre wr", 32'(fifo_wr), 32'(1));
        n_rst = 1'b0;
        #1;
        chk("rst wr",    32'(fifo_wr),     32'(0));
        chk("rst wdata", 32'(fifo_wdata),  32'(0));
        chk("rst busy",  32'(busy),        32'(0));
        chk("rst ovr",   32'(overrun_cnt), 32'(0));
        chk("rst frame", 32'(frame_cnt),   32'(0));
        adv();
        n_rst = 1'b1;
        extra = 0;
        for (int k = 0; k < int'(T) + 5; k++) begin
            settle();
            if (fifo_wr) extra++;
            adv();
        end
        chk("rst no push", 32'(extra), 32'(0));
        chk("rst busy after", 32'(busy), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
